// File: rtl/ql_bank_cfg_pkg.sv
// ----------------------------------------------------------------------------
// ql_bank_cfg_pkg
// Shared definitions for the QL memory-bank configuration controller:
//   - controller state encoding (ql_bank_cfg_state_e)
//   - default geometry and timing values used by the controller parameters
//   - ql_onehot(): range-checked one-hot word-line decode
// No ports (package).
// ----------------------------------------------------------------------------
package ql_bank_cfg_pkg;

    localparam int QL_BL_WIDTH_DEF  = 16;
    localparam int QL_WL_WIDTH_DEF  = 16;
    localparam int QL_SETUP_CYC_DEF = 1;
    localparam int QL_PULSE_CYC_DEF = 2;

    // Upper bound on word lines a decoder can address; the helper works on
    // a fixed-width vector so it can live in the package.
    localparam int QL_MAX_ADDR_W = 10;
    localparam int QL_MAX_WL     = 1 << QL_MAX_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        RD_PULSE,
        RESP
    } ql_bank_cfg_state_e;

    // Returns a vector with only bit 'addr' set, or all zeros when 'addr'
    // does not name one of the 'width' word lines.
    function automatic logic [QL_MAX_WL-1:0] ql_onehot(input logic [QL_MAX_ADDR_W-1:0] addr,
                                                       input int                       width);
        logic [QL_MAX_WL-1:0] vec;
        vec = '0;
        if ({{(32-QL_MAX_ADDR_W){1'b0}}, addr} < unsigned'(width)) begin
            vec[addr] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/ql_bank_wl_decoder.sv
// ----------------------------------------------------------------------------
// ql_bank_wl_decoder
// Registered one-hot word-line decoder with enable and address range check.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : drive the addressed line on the next clock edge
//   addr        : word-line address
//   onehot      : registered word lines, bit i is word line i (one-hot or zero)
//   in_range    : combinational, high when addr < WIDTH
// ----------------------------------------------------------------------------
module ql_bank_wl_decoder
    import ql_bank_cfg_pkg::*;
#(
    parameter int WIDTH  = QL_WL_WIDTH_DEF,
    parameter int ADDR_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [0:WIDTH-1]  onehot,
    output logic              in_range
);

    logic [QL_MAX_WL-1:0] dec_full;
    logic [0:WIDTH-1]     dec_next;

    assign dec_full = ql_onehot(QL_MAX_ADDR_W'(addr), WIDTH);
    assign in_range = |dec_full;

    // Map by index so that onehot[i] is word line i regardless of range direction.
    always_comb begin
        dec_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_next[i] = en & dec_full[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot <= '0;
        end else begin
            onehot <= dec_next;
        end
    end

endmodule

// File: rtl/ql_bank_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// ql_bank_cfg_ctrl
// Sequenced BL/WL programming controller for QL configuration SRAM banks.
// Accepts write/readback commands, drives the bit lines, pulses one word line
// (wl for writes, wlr for readback) and returns a response.
// Ports:
//   prog_clk, pResetN       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake
//   cmd_read/addr/data      : command fields (1 = readback)
//   rsp_valid/rsp_ready     : response handshake
//   rsp_data, rsp_err       : readback data (0 for writes), address error
//   bl                      : bit-line drive
//   wl, wlr                 : write / readback word lines
//   rd_bl                   : readback sense inputs
// All outputs are registered.
// ----------------------------------------------------------------------------
module ql_bank_cfg_ctrl
    import ql_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH  = QL_BL_WIDTH_DEF,
    parameter int WL_WIDTH  = QL_WL_WIDTH_DEF,
    parameter int WL_ADDR_W = $clog2(WL_WIDTH),
    parameter int SETUP_CYC = QL_SETUP_CYC_DEF,
    parameter int PULSE_CYC = QL_PULSE_CYC_DEF
) (
    input  logic                 prog_clk,
    input  logic                 pResetN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_read,
    input  logic [WL_ADDR_W-1:0] cmd_addr,
    input  logic [BL_WIDTH-1:0]  cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BL_WIDTH-1:0]  rsp_data,
    output logic                 rsp_err,
    output logic [0:BL_WIDTH-1]  bl,
    output logic [0:WL_WIDTH-1]  wl,
    output logic [0:WL_WIDTH-1]  wlr,
    input  logic [0:BL_WIDTH-1]  rd_bl
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

    if (SETUP_CYC < 1) begin : g_chk_setup
        $error("ql_bank_cfg_ctrl: SETUP_CYC must be at least 1");
    end
    if (PULSE_CYC < 1) begin : g_chk_pulse
        $error("ql_bank_cfg_ctrl: PULSE_CYC must be at least 1");
    end
    if (WL_WIDTH < 2 || WL_WIDTH > QL_MAX_WL) begin : g_chk_wl
        $error("ql_bank_cfg_ctrl: WL_WIDTH out of supported range");
    end

    ql_bank_cfg_state_e   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WL_ADDR_W-1:0] addr_q, addr_d;
    logic [BL_WIDTH-1:0]  data_q, data_d;
    logic                 handshake;
    logic                 addr_ok, wl_ok, wlr_ok;
    logic                 accept_err, capture_rd, rsp_done;

    // Outputs are registered from the next state, so the command fields must
    // be visible in the same cycle as the handshake that delivers them.
    assign handshake = cmd_valid & cmd_ready;
    assign addr_d    = handshake ? cmd_addr : addr_q;
    assign data_d    = handshake ? cmd_data : data_q;

    // Both decoders see the same address; either one rejecting it is an error.
    assign addr_ok = wl_ok & wlr_ok;

    // One shared down-counter times every phase; it is loaded with length-1 on
    // entry and the phase ends when it reaches zero. The read/write choice is
    // captured by which path the FSM takes, so no separate flag is stored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_err = 1'b0;
        capture_rd = 1'b0;
        rsp_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (!addr_ok) begin
                        state_d    = RESP;
                        accept_err = 1'b1;
                    end else if (cmd_read) begin
                        state_d = RD_PULSE;
                        cnt_d   = PULSE_LOAD;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = RESP;
            end
            RD_PULSE: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    capture_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    rsp_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pResetN) begin
        if (!pResetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            bl        <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cmd_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            bl        <= (state_d inside {SETUP, PULSE, HOLD}) ? data_d : '0;
            if (rsp_done) begin
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end else if (accept_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end else if (capture_rd) begin
                rsp_data <= rd_bl;
            end
        end
    end

    ql_bank_wl_decoder #(
        .WIDTH  (WL_WIDTH),
        .ADDR_W (WL_ADDR_W)
    ) u_wl_dec (
        .clk      (prog_clk),
        .rst_n    (pResetN),
        .en       (state_d == PULSE),
        .addr     (addr_d),
        .onehot   (wl),
        .in_range (wl_ok)
    );

    ql_bank_wl_decoder #(
        .WIDTH  (WL_WIDTH),
        .ADDR_W (WL_ADDR_W)
    ) u_wlr_dec (
        .clk      (prog_clk),
        .rst_n    (pResetN),
        .en       (state_d == RD_PULSE),
        .addr     (addr_d),
        .onehot   (wlr),
        .in_range (wlr_ok)
    );

endmodule

// File: tb/tb_ql_bank_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ql_bank_cfg_ctrl
// Two controllers share all inputs: 'a' uses default parameters, 'b' uses
// WL_WIDTH=12, SETUP_CYC=3, PULSE_CYC=4. Each command pushes the expected
// response per controller into a queue; monitors pop and compare whenever a
// response appears. Bus waveforms are compared cycle by cycle against a model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ql_bank_cfg_ctrl;

    localparam int A_W = 16, A_S = 1, A_P = 2;
    localparam int B_W = 12, B_S = 3, B_P = 4;

    typedef struct {
        int          hs;
        int          lat;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        prog_clk = 1'b0;
    logic        pResetN  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_read  = 1'b0;
    logic [3:0]  cmd_addr  = '0;
    logic [15:0] cmd_data  = '0;
    logic        rsp_ready = 1'b1;
    logic [0:15] rd_bl     = '0;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_err;
    logic [15:0] a_rsp_data;
    logic [0:15] a_bl, a_wl, a_wlr;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_err;
    logic [15:0] b_rsp_data;
    logic [0:15] b_bl;
    logic [0:11] b_wl, b_wlr;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    ql_bank_cfg_ctrl u_a (
        .prog_clk (prog_clk), .pResetN (pResetN),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_read(cmd_read),
        .cmd_addr (cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data (a_rsp_data), .rsp_err(a_rsp_err),
        .bl(a_bl), .wl(a_wl), .wlr(a_wlr), .rd_bl(rd_bl)
    );

    ql_bank_cfg_ctrl #(
        .WL_WIDTH (B_W), .SETUP_CYC(B_S), .PULSE_CYC(B_P)
    ) u_b (
        .prog_clk (prog_clk), .pResetN (pResetN),
        .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_read(cmd_read),
        .cmd_addr (cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data (b_rsp_data), .rsp_err(b_rsp_err),
        .bl(b_bl), .wl(b_wl), .wlr(b_wlr), .rd_bl(rd_bl)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at cyc %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [0:15] oneHot(input int addr);
        logic [0:15] v;
        v = '0;
        if (addr >= 0 && addr < 16) v[addr[3:0]] = 1'b1;
        return v;
    endfunction

    function automatic exp_t expResp(input int w, input int s, input int p, input logic rd,
                                     input int addr, input logic [15:0] rdv, input int hs);
        exp_t e;
        e.hs   = hs;
        e.err  = (addr >= w);
        e.lat  = e.err ? 1 : (rd ? p + 1 : s + p + 2);
        e.data = (e.err || !rd) ? 16'h0 : rdv;
        return e;
    endfunction

    // Expected bus state in cycle k after the handshake edge.
    task automatic modelWave(input int w, input int s, input int p, input int k,
                             input logic rd, input int addr, input logic [15:0] data,
                             output logic [15:0] eBl, output logic [0:15] eWl, output logic [0:15] eWlr);
        eBl  = '0;
        eWl  = '0;
        eWlr = '0;
        if (addr < w) begin
            if (rd) begin
                if (k >= 1 && k <= p) eWlr = oneHot(addr);
            end else begin
                if (k >= 1 && k <= s + p + 1) eBl = data;
                if (k >= s + 1 && k <= s + p) eWl = oneHot(addr);
            end
        end
    endtask

    task automatic checkCycle(input int k, input logic rd, input int addr, input logic [15:0] data);
        logic [15:0] eBl;
        logic [0:15] eWl, eWlr;
        modelWave(A_W, A_S, A_P, k, rd, addr, data, eBl, eWl, eWlr);
        checkOutput($sformatf("a_bl@%0d", k),  32'(a_bl),  32'(eBl));
        checkOutput($sformatf("a_wl@%0d", k),  32'(a_wl),  32'(eWl));
        checkOutput($sformatf("a_wlr@%0d", k), 32'(a_wlr), 32'(eWlr));
        modelWave(B_W, B_S, B_P, k, rd, addr, data, eBl, eWl, eWlr);
        checkOutput($sformatf("b_bl@%0d", k),  32'(b_bl),  32'(eBl));
        checkOutput($sformatf("b_wl@%0d", k),  32'(b_wl),  32'(eWl[0:11]));
        checkOutput($sformatf("b_wlr@%0d", k), 32'(b_wlr), 32'(eWlr[0:11]));
    endtask

    // Issues one command once both controllers are ready; returns in cycle 1.
    task automatic applyStimulus(input logic rd, input int addr, input logic [15:0] data,
                                 input logic [15:0] rdv, input bit track);
        int waitCyc = 0;
        @(negedge prog_clk);
        while (!(a_cmd_ready && b_cmd_ready) && waitCyc < 50) begin
            @(negedge prog_clk);
            waitCyc++;
        end
        checkOutput("cmd_ready_wait", 32'(a_cmd_ready & b_cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr[3:0];
        cmd_data  = data;
        rd_bl     = rdv;
        if (track) begin
            q_a.push_back(expResp(A_W, A_S, A_P, rd, addr, rdv, cyc));
            q_b.push_back(expResp(B_W, B_S, B_P, rd, addr, rdv, cyc));
        end
        @(negedge prog_clk);
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic runWave(input logic rd, input int addr, input logic [15:0] data, input int n);
        for (int k = 1; k <= n; k++) begin
            checkCycle(k, rd, addr, data);
            @(negedge prog_clk);
        end
    endtask

    bit   actA = 1'b0;
    bit   actB = 1'b0;
    exp_t curA, curB;

    always @(negedge prog_clk) begin
        if (a_rsp_valid) begin
            if (!actA) begin
                actA = 1'b1;
                checkOutput("a_rsp_pending", 32'(q_a.size()), 32'd1);
                if (q_a.size() != 0) begin
                    curA = q_a.pop_front();
                    checkOutput("a_rsp_latency", 32'(cyc - curA.hs), 32'(curA.lat));
                end
            end
            checkOutput("a_rsp_data", 32'(a_rsp_data), 32'(curA.data));
            checkOutput("a_rsp_err",  32'(a_rsp_err),  32'(curA.err));
        end else begin
            actA = 1'b0;
            checkOutput("a_rsp_idle", 32'({a_rsp_err, a_rsp_data}), 32'd0);
        end
    end

    always @(negedge prog_clk) begin
        if (b_rsp_valid) begin
            if (!actB) begin
                actB = 1'b1;
                checkOutput("b_rsp_pending", 32'(q_b.size()), 32'd1);
                if (q_b.size() != 0) begin
                    curB = q_b.pop_front();
                    checkOutput("b_rsp_latency", 32'(cyc - curB.hs), 32'(curB.lat));
                end
            end
            checkOutput("b_rsp_data", 32'(b_rsp_data), 32'(curB.data));
            checkOutput("b_rsp_err",  32'(b_rsp_err),  32'(curB.err));
        end else begin
            actB = 1'b0;
            checkOutput("b_rsp_idle", 32'({b_rsp_err, b_rsp_data}), 32'd0);
        end
    end

    initial begin
        #1 pResetN = 1'b0;
        repeat (2) @(negedge prog_clk);
        $display("[TB] reset state");
        checkOutput("rst_a_cmd_ready", 32'(a_cmd_ready), 32'd0);
        checkOutput("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd0);
        checkOutput("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("rst_a_buses", 32'(|{a_bl, a_wl, a_wlr}), 32'd0);
        checkOutput("rst_b_buses", 32'(|{b_bl, b_wl, b_wlr}), 32'd0);
        pResetN = 1'b1;
        @(negedge prog_clk);
        checkOutput("rel_a_cmd_ready", 32'(a_cmd_ready), 32'd1);
        checkOutput("rel_b_cmd_ready", 32'(b_cmd_ready), 32'd1);

        $display("[TB] write addr 3");
        applyStimulus(1'b0, 3, 16'hA5C3, 16'h0000, 1'b1);
        runWave(1'b0, 3, 16'hA5C3, 9);

        $display("[TB] read addr 15 (b out of range)");
        applyStimulus(1'b1, 15, 16'h0000, 16'h1234, 1'b1);
        runWave(1'b1, 15, 16'h0000, 3);

        $display("[TB] write addr 13 (b out of range)");
        applyStimulus(1'b0, 13, 16'h5AA5, 16'h0000, 1'b1);
        runWave(1'b0, 13, 16'h5AA5, 5);

        $display("[TB] read addr 11");
        applyStimulus(1'b1, 11, 16'h0000, 16'hC0DE, 1'b1);
        runWave(1'b1, 11, 16'h0000, 5);

        $display("[TB] write addr 0");
        applyStimulus(1'b0, 0, 16'hFFFF, 16'h0000, 1'b1);
        runWave(1'b0, 0, 16'hFFFF, 9);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 5, 16'h0F0F, 16'h0000, 1'b1);
        runWave(1'b0, 5, 16'h0F0F, 9);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_a_cmd_ready", 32'(a_cmd_ready), 32'd0);
            checkOutput("bp_b_cmd_ready", 32'(b_cmd_ready), 32'd0);
            @(negedge prog_clk);
        end
        rsp_ready = 1'b1;
        @(negedge prog_clk);
        checkOutput("bp_rel_a_cmd_ready", 32'(a_cmd_ready), 32'd1);
        checkOutput("bp_rel_b_cmd_ready", 32'(b_cmd_ready), 32'd1);
        checkOutput("bp_rel_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("bp_rel_b_rsp_valid", 32'(b_rsp_valid), 32'd0);

        $display("[TB] reset mid-pulse");
        applyStimulus(1'b0, 2, 16'h3C3C, 16'h0000, 1'b0);
        @(negedge prog_clk);
        checkOutput("mid_a_wl_before", 32'(a_wl), 32'(oneHot(2)));
        checkOutput("mid_b_bl_before", 32'(b_bl), 32'h3C3C);
        #2 pResetN = 1'b0;
        #1;
        checkOutput("mid_a_wl_async", 32'(a_wl), 32'd0);
        checkOutput("mid_a_bl_async", 32'(a_bl), 32'd0);
        checkOutput("mid_b_bl_async", 32'(b_bl), 32'd0);
        checkOutput("mid_a_cmd_ready", 32'(a_cmd_ready), 32'd0);
        repeat (2) @(negedge prog_clk);
        pResetN = 1'b1;
        @(negedge prog_clk);
        checkOutput("mid_rel_a_cmd_ready", 32'(a_cmd_ready), 32'd1);
        checkOutput("mid_rel_b_cmd_ready", 32'(b_cmd_ready), 32'd1);

        $display("[TB] read addr 7 after reset");
        applyStimulus(1'b1, 7, 16'h0000, 16'hBEEF, 1'b1);
        runWave(1'b1, 7, 16'h0000, 5);

        repeat (3) @(negedge prog_clk);
        checkOutput("end_q_a_empty", 32'(q_a.size()), 32'd0);
        checkOutput("end_q_b_empty", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ql_bank_cfg_ctrl.md
# ql_bank_cfg_ctrl

Parametrised programming controller for QL memory-bank configuration arrays built from BL/WL-addressed SRAM cells. It accepts word-level write and readback commands over a valid/ready interface. For each command it drives the bit-line bus and pulses one word line (WL) or readback word line (WLR) with programmable setup and pulse widths, then returns a response. It sits between the fabric-level configuration protocol front end and the tile `bl`/`wl` buses, replacing static per-bit BL/WL wiring with sequenced, glitch-free programming.

## Interface
Parameters:
- `BL_WIDTH`, 16: number of bit lines, equal to the bits per configuration word.
- `WL_WIDTH`, 16: number of word lines; must be ≥ 2.
- `WL_ADDR_W`, `$clog2(WL_WIDTH)`: width of the word-line address.
- `SETUP_CYC`, 1: cycles the BL bus is stable before the WL pulse; must be ≥ 1.
- `PULSE_CYC`, 2: WL/WLR pulse width in cycles; must be ≥ 1.

Ports:
- `prog_clk` in 1: programming clock.
- `pResetN` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_read` in 1: 1 = readback, 0 = write.
- `cmd_addr` in `WL_ADDR_W`: target word line.
- `cmd_data` in `BL_WIDTH`: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out `BL_WIDTH`: readback data; 0 for writes.
- `rsp_err` out 1: address was out of range.
- `bl` out [0:`BL_WIDTH`-1]: bit-line drive.
- `wl` out [0:`WL_WIDTH`-1]: write word lines, one-hot or all-zero.
- `wlr` out [0:`WL_WIDTH`-1]: readback word lines, one-hot or all-zero.
- `rd_bl` in [0:`BL_WIDTH`-1]: readback bit-line sense inputs.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, RD_PULSE, RESP.
- **IDLE**
  - `cmd_ready` = 1; `bl`, `wl`, `wlr` = 0.
  - A handshake (`cmd_valid` && `cmd_ready`) latches addr, data and read.
- **Out-of-range address** (`cmd_addr` ≥ `WL_WIDTH`)
  - Go directly to RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - No BL/WL/WLR activity occurs.
- **Write**
  - SETUP: `bl` = data, `wl` = 0, for `SETUP_CYC` cycles.
  - PULSE: `wl[addr]` = 1, `bl` held, for `PULSE_CYC` cycles.
  - HOLD: `wl` = 0, `bl` held, for 1 cycle.
  - RESP follows HOLD.
- **Readback**
  - RD_PULSE: `bl` = 0, `wlr[addr]` = 1, for `PULSE_CYC` cycles.
  - `rd_bl` is sampled into `rsp_data` on the last pulse cycle; then go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data` and `rsp_err` stay stable until `rsp_ready`.
  - `bl`, `wl`, `wlr` = 0 during RESP.
  - On `rsp_ready`, go to IDLE; `rsp_err` and `rsp_data` clear to 0.
- Phase lengths use one shared down-counter of width `$clog2(max(SETUP_CYC,PULSE_CYC))+1`, loaded on each state entry.
- `wl` and `wlr` are never asserted together, and never with more than one bit set.

## Timing
- **Reset:** while `pResetN` = 0, all outputs go to 0 immediately (asynchronously), including `cmd_ready`, and the state is IDLE. `cmd_ready` rises on the first clock edge after deassertion.
- **Reset mid-pulse:** WL drops asynchronously and the command is discarded; no response is issued.
- **Registered outputs:** all outputs are driven from flops, so there are no combinational paths from inputs to outputs.
- **Latency:** cycle 0 is the handshake edge.
  - Write: `rsp_valid` first high in cycle `SETUP_CYC`+`PULSE_CYC`+2 (5 with defaults).
  - Read: `rsp_valid` first high in cycle `PULSE_CYC`+1 (3 with defaults).
  - Error: `rsp_valid` first high in cycle 1.
- **Back-to-back commands:** there is no overlap. The next handshake is possible one cycle after the `rsp_ready` handshake, because `cmd_ready` is registered.
- **`rsp_ready` held high:** RESP lasts exactly 1 cycle.
- **Write WL envelope:** WL rises ≥ `SETUP_CYC` cycles after BL is valid and falls 1 cycle before BL changes.

## Structure
- Package `ql_bank_cfg_pkg` holds:
  - the state enum `ql_bank_cfg_state_e`;
  - the default localparams;
  - a helper function `ql_onehot(addr, width)`.
- Sub-module `ql_bank_wl_decoder`:
  - registered one-hot decoder with enable and range-check output;
  - one instance each for `wl` and `wlr`.
- Elaboration-time assertions check `SETUP_CYC` ≥ 1, `PULSE_CYC` ≥ 1 and `WL_WIDTH` ≥ 2.

## Test plan
- **Write, defaults:** write addr 3, data 0xA5C3 → `bl` = 0xA5C3 from cycle 1; `wl` = 1<<3 in cycles 2–3; `wl` = 0 in cycle 4; `rsp_valid` in cycle 5 with `rsp_err` = 0 and `rsp_data` = 0.
- **Readback:** `rd_bl` = 0x1234, read addr 15 → `wlr[15]` high in cycles 1–2; `rsp_data` = 0x1234 in cycle 3; `wl` stays 0 throughout.
- **Out of range:** `WL_WIDTH` = 12, addr 13 → `rsp_err` = 1 in cycle 1; no `wl`/`wlr`/`bl` activity.
- **Backpressure:** hold `rsp_ready` = 0 for 10 cycles → `rsp_valid`/`rsp_data` stable and `cmd_ready` = 0; after the release, `cmd_ready` = 1 on the next cycle.
- **Reset mid-pulse:** assert `pResetN` = 0 during cycle 2 → `wl` = 0 in the same cycle (asynchronously) and no response is issued; after release, the next command completes normally.
- **Parameter sweep:** `SETUP_CYC` = 3, `PULSE_CYC` = 4 → WL high for exactly 4 cycles; write `rsp_valid` in cycle 9.
